// File: rtl/freq_cmd_pkg.sv
// ============================================================================
// Module      : freq_cmd_pkg
// Description : Command-frame constants and parser state encoding shared by
//               the divider-update receiver and the host-side tools.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package freq_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam logic [7:0] CMD_SET_DIV = 8'h01;

  typedef enum logic [1:0] {
    P_SYNC = 2'd0,
    P_CMD  = 2'd1,
    P_DATA = 2'd2,
    P_CSUM = 2'd3
  } parser_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_byte_rx.sv
// ============================================================================
// Module      : uart_byte_rx
// Description : Two-flop input synchroniser plus 8N1 byte receiver with
//               mid-bit sampling; flags stop-bit framing errors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_byte_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       rx_ferr
);

  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic [1:0]    sync_q;
  logic          rx_s;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          byte_valid_q, rx_ferr_q;
  logic          cnt_done;
  logic          stop_ok_d, stop_bad_d;

  assign rx_s     = sync_q[1];
  assign cnt_done = (state_q == RX_START) ? (cnt_q == HALF_M1) : (cnt_q == FULL_M1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= RX_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (!rx_s) state_d = RX_START;
      RX_START: if (cnt_done) state_d = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (cnt_done && bit_q == 3'd7) state_d = RX_STOP;
      RX_STOP:  if (cnt_done) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    stop_ok_d  = (state_q == RX_STOP) && cnt_done && rx_s;
    stop_bad_d = (state_q == RX_STOP) && cnt_done && !rx_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q       <= 2'b11;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      rx_ferr_q    <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], uart_rx};
      byte_valid_q <= stop_ok_d;
      rx_ferr_q    <= stop_bad_d;
      // The bit timer restarts at each sample point, giving one-bit spacing.
      if (state_q == RX_IDLE || cnt_done) cnt_q <= '0;
      else                                cnt_q <= cnt_q + CNT_ONE;
      if (state_q == RX_DATA && cnt_done) begin
        shift_q <= {rx_s, shift_q[7:1]};
        bit_q   <= bit_q + 3'd1;
      end else if (state_q != RX_DATA) begin
        bit_q <= '0;
      end
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = shift_q;
  assign rx_ferr    = rx_ferr_q;

endmodule

`default_nettype wire

// File: rtl/freq_cmd_rx.sv
// ============================================================================
// Module      : freq_cmd_rx
// Description : UART-framed divider-update receiver; validates A5/01 frames
//               with XOR checksum and drives the sine generator's clk_div.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module freq_cmd_rx
  import freq_cmd_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [31:0] DIV_RESET    = 32'd1000,
  parameter int          TIMEOUT_CLKS = 20 * CLKS_PER_BIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic [31:0] clk_div,
  output logic        cmd_ack,
  output logic        frame_err
);

  localparam int            TW      = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TO_M1   = TW'(TIMEOUT_CLKS - 1);
  localparam logic [TW-1:0] TMR_ONE = TW'(1);

  logic          byte_valid, rx_ferr;
  logic [7:0]    byte_data;
  parser_state_t state_q, state_d;
  logic [31:0]   shadow_q, clk_div_q;
  logic [7:0]    xor_q;
  logic [1:0]    cnt_q;
  logic [TW-1:0] tmr_q;
  logic          cmd_ack_q, frame_err_q;
  logic          cmd_ack_d, frame_err_d;
  logic          abort, csum_ok;

  uart_byte_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .uart_rx    (uart_rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .rx_ferr    (rx_ferr)
  );

  // A received byte always wins over a simultaneous timeout.
  assign abort   = (state_q != P_SYNC) && !byte_valid && (rx_ferr || tmr_q == TO_M1);
  assign csum_ok = (byte_data == xor_q) && (shadow_q != '0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= P_SYNC;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (byte_valid) begin
      case (state_q)
        P_SYNC:  if (byte_data == SYNC_BYTE) state_d = P_CMD;
        P_CMD:   state_d = (byte_data == CMD_SET_DIV) ? P_DATA : P_SYNC;
        P_DATA:  if (cnt_q == 2'd3) state_d = P_CSUM;
        default: state_d = P_SYNC;
      endcase
    end else if (abort) begin
      state_d = P_SYNC;
    end
  end

  always_comb begin
    cmd_ack_d   = 1'b0;
    frame_err_d = 1'b0;
    if (byte_valid) begin
      case (state_q)
        P_CMD:   frame_err_d = (byte_data != CMD_SET_DIV);
        P_CSUM: begin
          cmd_ack_d   = csum_ok;
          frame_err_d = !csum_ok;
        end
        default: ;
      endcase
    end else if (abort) begin
      frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_div_q   <= DIV_RESET;
      shadow_q    <= '0;
      xor_q       <= '0;
      cnt_q       <= '0;
      tmr_q       <= '0;
      cmd_ack_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      cmd_ack_q   <= cmd_ack_d;
      frame_err_q <= frame_err_d;
      if (cmd_ack_d) clk_div_q <= shadow_q;
      if (byte_valid || state_d == P_SYNC) tmr_q <= '0;
      else                                 tmr_q <= tmr_q + TMR_ONE;
      if (byte_valid && state_q == P_CMD) begin
        shadow_q <= '0;
        xor_q    <= byte_data;
        cnt_q    <= '0;
      end else if (byte_valid && state_q == P_DATA) begin
        shadow_q <= {shadow_q[23:0], byte_data};
        xor_q    <= xor_q ^ byte_data;
        cnt_q    <= cnt_q + 2'd1;
      end
    end
  end

  assign clk_div   = clk_div_q;
  assign cmd_ack   = cmd_ack_q;
  assign frame_err = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_freq_cmd_rx.sv
// ============================================================================
// Module      : tb_freq_cmd_rx
// Description : Self-checking bench for freq_cmd_rx: directed frames plus
//               randomized frame streams against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_freq_cmd_rx;

  localparam int          CPB     = 4;
  localparam int          TO_CLKS = 80;
  localparam logic [31:0] DIV_RST = 32'd1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx = 1'b1;
  logic [31:0] clk_div;
  logic        cmd_ack, frame_err;

  int n_checks = 0;
  int n_pass   = 0;
  int ack_total  = 0;
  int ferr_total = 0;
  logic [31:0] exp_div = DIV_RST;

  always #5 clk = ~clk;

  freq_cmd_rx #(
    .CLKS_PER_BIT (CPB),
    .DIV_RESET    (DIV_RST),
    .TIMEOUT_CLKS (TO_CLKS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .clk_div   (clk_div),
    .cmd_ack   (cmd_ack),
    .frame_err (frame_err)
  );

  // Pulse-shape and output-stability monitor
  logic        rst_at_edge = 1'b1;
  logic        prev_ack = 1'b0, prev_ferr = 1'b0;
  logic [31:0] prev_div = DIV_RST;

  always @(posedge clk) rst_at_edge <= rst;

  always @(negedge clk) begin
    if (cmd_ack === 1'b1) ack_total++;
    if (frame_err === 1'b1) ferr_total++;
    if (cmd_ack === 1'b1 || frame_err === 1'b1) begin
      n_checks++;
      if (cmd_ack && frame_err)
        $display("FAIL pulse_exclusive: ack=%0b err=%0b, required not both", cmd_ack, frame_err);
      else if ((prev_ack && cmd_ack) || (prev_ferr && frame_err))
        $display("FAIL pulse_width: pulse wider than 1 cycle at %0t", $time);
      else
        n_pass++;
    end
    if (clk_div !== prev_div) begin
      n_checks++;
      if (cmd_ack !== 1'b1 && !rst_at_edge)
        $display("FAIL div_stability: clk_div %0h->%0h without cmd_ack", prev_div, clk_div);
      else
        n_pass++;
    end
    prev_ack  = cmd_ack;
    prev_ferr = frame_err;
    prev_div  = clk_div;
  end

  // Frame-level reference model: {A5, 01, D3..D0, CK} packed MSB-first
  function automatic logic [55:0] make_frame(input logic [31:0] div);
    logic [7:0] ck;
    ck = 8'h01 ^ div[31:24] ^ div[23:16] ^ div[15:8] ^ div[7:0];
    return {8'hA5, 8'h01, div, ck};
  endfunction

  function automatic logic frame_ok(input logic [55:0] f);
    logic [7:0] ck;
    ck = f[47:40] ^ f[39:32] ^ f[31:24] ^ f[23:16] ^ f[15:8];
    return (f[55:48] == 8'hA5) && (f[47:40] == 8'h01) && (f[7:0] == ck) && (f[39:8] != 32'd0);
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic send_frame(input logic [55:0] f);
    for (int i = 0; i < 7; i++) send_byte(f[55 - 8*i -: 8], 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (clk_div !== DIV_RST) $display("FAIL reset_div: got %0d want %0d", clk_div, DIV_RST);
    else n_pass++;
    n_checks++;
    if (cmd_ack !== 1'b0 || frame_err !== 1'b0)
      $display("FAIL reset_pulses: ack=%0b err=%0b want 0/0", cmd_ack, frame_err);
    else n_pass++;
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_valid_frame();
    int a0, f0;
    a0 = ack_total; f0 = ferr_total;
    send_frame(56'hA5_01_00_01_86_A0_26);
    @(negedge clk);
    n_checks++;
    if (cmd_ack !== 1'b0 || clk_div !== DIV_RST)
      $display("FAIL valid_early: ack=%0b div=%0d, want 0 and %0d", cmd_ack, clk_div, DIV_RST);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (cmd_ack !== 1'b1) $display("FAIL valid_ack_latency: ack=%0b want 1", cmd_ack);
    else n_pass++;
    n_checks++;
    if (clk_div !== 32'd100000) $display("FAIL valid_div: got %0d want 100000", clk_div);
    else n_pass++;
    exp_div = 32'd100000;
    repeat (6) @(negedge clk);
    n_checks++;
    if (ack_total - a0 != 1 || ferr_total - f0 != 0)
      $display("FAIL valid_counts: acks=%0d errs=%0d want 1/0", ack_total - a0, ferr_total - f0);
    else n_pass++;
  endtask

  task automatic reject_frame(input logic [55:0] f, input string name);
    int a0, f0;
    a0 = ack_total; f0 = ferr_total;
    send_frame(f);
    repeat (8) @(negedge clk);
    n_checks++;
    if (ack_total - a0 != 0 || ferr_total - f0 != 1)
      $display("FAIL %s_counts: acks=%0d errs=%0d want 0/1", name, ack_total - a0, ferr_total - f0);
    else n_pass++;
    n_checks++;
    if (clk_div !== exp_div) $display("FAIL %s_div: got %0d want %0d", name, clk_div, exp_div);
    else n_pass++;
  endtask

  task automatic test_bad_checksum();
    // Start from the reset divider so the held value is 1000.
    rst = 1'b1; @(negedge clk); rst = 1'b0; exp_div = DIV_RST;
    repeat (2) @(negedge clk);
    reject_frame(56'hA5_01_00_01_86_A0_27, "bad_csum");
  endtask

  task automatic test_zero_div();
    reject_frame(56'hA5_01_00_00_00_00_01, "zero_div");
  endtask

  task automatic test_frame_error();
    int a0, f0;
    send_frame(make_frame(32'd77777));
    exp_div = 32'd77777;
    repeat (6) @(negedge clk);
    a0 = ack_total; f0 = ferr_total;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h55, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    n_checks++;
    if (ferr_total - f0 != 1 || ack_total - a0 != 0)
      $display("FAIL ferr_abort: errs=%0d acks=%0d want 1/0", ferr_total - f0, ack_total - a0);
    else n_pass++;
    send_frame(56'hA5_01_00_00_03_E8_EA);
    exp_div = 32'd1000;
    repeat (6) @(negedge clk);
    n_checks++;
    if (ack_total - a0 != 1 || clk_div !== 32'd1000)
      $display("FAIL ferr_recover: acks=%0d div=%0d want 1/1000", ack_total - a0, clk_div);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int f0, a0, hit;
    f0 = ferr_total; a0 = ack_total; hit = -1;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    // Cycle 1 after the last stop sample is the byte_valid cycle.
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (frame_err === 1'b1 && hit < 0) hit = i - 1;
    end
    n_checks++;
    if (ferr_total - f0 != 1) $display("FAIL timeout_count: errs=%0d want 1", ferr_total - f0);
    else n_pass++;
    n_checks++;
    if (hit < TO_CLKS - 1 || hit > TO_CLKS + 2)
      $display("FAIL timeout_latency: got %0d cycles want about %0d", hit, TO_CLKS);
    else n_pass++;
    send_frame(56'hA5_01_00_00_C3_50_92);
    exp_div = 32'd50000;
    repeat (6) @(negedge clk);
    n_checks++;
    if (ack_total - a0 != 1 || clk_div !== 32'd50000)
      $display("FAIL timeout_recover: acks=%0d div=%0d want 1/50000", ack_total - a0, clk_div);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int a0, f0;
    send_frame(make_frame(32'd100000));
    repeat (6) @(negedge clk);
    n_checks++;
    if (clk_div !== 32'd100000) $display("FAIL rstmid_load: got %0d want 100000", clk_div);
    else n_pass++;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_div = DIV_RST;
    n_checks++;
    if (clk_div !== DIV_RST) $display("FAIL rstmid_div: got %0d want %0d", clk_div, DIV_RST);
    else n_pass++;
    repeat (2) @(negedge clk);
    a0 = ack_total; f0 = ferr_total;
    send_byte(8'h01, 1'b1);
    send_byte(8'h86, 1'b1);
    send_byte(8'hA0, 1'b1);
    send_byte(8'h26, 1'b1);
    repeat (TO_CLKS + 10) @(negedge clk);
    n_checks++;
    if (ack_total != a0 || ferr_total != f0 || clk_div !== DIV_RST)
      $display("FAIL rstmid_tail: acks=%0d errs=%0d div=%0d want 0/0/%0d",
               ack_total - a0, ferr_total - f0, clk_div, DIV_RST);
    else n_pass++;
  endtask

  function automatic logic [55:0] random_frame();
    logic [55:0] f;
    logic [31:0] d;
    logic [7:0]  flip;
    d = $urandom;
    case ($urandom_range(0, 3))
      2: begin
        f = make_frame(d);
        flip = 8'($urandom_range(1, 255));
        f[7:0] = f[7:0] ^ flip;
      end
      3:       f = make_frame(32'd0);
      default: f = make_frame(d);
    endcase
    return f;
  endfunction

  task automatic test_random_frames();
    logic [55:0] f;
    logic [7:0]  junk;
    int a0, f0;
    for (int n = 0; n < 10; n++) begin
      f = random_frame();
      a0 = ack_total; f0 = ferr_total;
      junk = 8'($urandom_range(0, 255));
      if (junk == 8'hA5) junk = 8'h5A;
      send_byte(junk, 1'b1);
      repeat ($urandom_range(0, 12)) @(negedge clk);
      send_frame(f);
      if (frame_ok(f)) exp_div = f[39:8];
      repeat (8) @(negedge clk);
      n_checks++;
      if (ack_total - a0 != int'(frame_ok(f)) || ferr_total - f0 != int'(!frame_ok(f)))
        $display("FAIL rand_counts[%0d]: frame=%h acks=%0d errs=%0d", n, f, ack_total - a0, ferr_total - f0);
      else n_pass++;
      n_checks++;
      if (clk_div !== exp_div) $display("FAIL rand_div[%0d]: got %h want %h", n, clk_div, exp_div);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [55:0] f;
    int a0, f0, exp_a, exp_f;
    a0 = ack_total; f0 = ferr_total; exp_a = 0; exp_f = 0;
    for (int n = 0; n < 8; n++) begin
      f = random_frame();
      send_frame(f);
      if (frame_ok(f)) begin exp_div = f[39:8]; exp_a++; end
      else exp_f++;
    end
    repeat (8) @(negedge clk);
    n_checks++;
    if (ack_total - a0 != exp_a || ferr_total - f0 != exp_f)
      $display("FAIL b2b_counts: acks=%0d errs=%0d want %0d/%0d", ack_total - a0, ferr_total - f0, exp_a, exp_f);
    else n_pass++;
    n_checks++;
    if (clk_div !== exp_div) $display("FAIL b2b_div: got %h want %h", clk_div, exp_div);
    else n_pass++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_valid_frame();
    test_bad_checksum();
    test_zero_div();
    test_frame_error();
    test_timeout();
    test_reset_mid_frame();
    test_random_frames();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/freq_cmd_rx.md
# freq_cmd_rx

Receives divider-update commands over a UART line and drives the 32-bit `clk_div` word consumed by the sine generator's clock divider. The host can retune the output frequency at run time without reconfiguring the device. The block contains a byte-level UART receiver and a framed-command parser, and holds the active divider value in a register.

## Interface
- `CLKS_PER_BIT`, default 434: `clk` cycles per UART bit (50 MHz / 115200). Must be ≥ 4.
- `DIV_RESET`, default 32'd1000: `clk_div` value after reset.
- `TIMEOUT_CLKS`, default 20*CLKS_PER_BIT: maximum idle `clk` cycles between bytes of one frame.
- `clk`  in  1  system clock; the single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `uart_rx`  in  1  asynchronous serial input, idle high, 8N1, LSB first.
- `clk_div`  out  32  active divider value; feeds the sine generator's `clk_div` input.
- `cmd_ack`  out  1  one-cycle pulse when a valid frame updates `clk_div`.
- `frame_err`  out  1  one-cycle pulse when a frame is rejected.

## Operation
- **Input sync:** `uart_rx` passes through 2 flops, reset to 1. All logic uses the synced bit.
- **Byte receiver states:** IDLE → START → DATA → STOP → IDLE.
  - IDLE: waits for a synced 0. START samples at CLKS_PER_BIT/2. If the sample is 1, the start was false; return to IDLE with no output.
  - DATA: takes 8 samples, each CLKS_PER_BIT apart, LSB first.
  - STOP: samples one bit. If 1, pulse `byte_valid` for 1 cycle with the byte. If 0, pulse `rx_ferr` and discard the byte.
  - The receiver returns to IDLE right after the stop sample, so the next start edge can be caught from that point.
- **Frame format:** `A5`, `01`, D3, D2, D1, D0 (divider, MSB first), CK. CK = XOR of bytes 1–5.
- **Parser states:** SYNC, CMD, DATA (4-byte counter), CSUM.
  - SYNC: `A5` → CMD. Any other byte is ignored with no error.
  - CMD: `01` → DATA, with a shadow register and running XOR initialised. Any other byte → `frame_err`, go to SYNC.
  - DATA: shift each byte into the 32-bit shadow and fold it into the XOR. After the 4th byte → CSUM.
  - CSUM: if CK matches and shadow ≠ 0, load `clk_div` from shadow and pulse `cmd_ack`. Otherwise pulse `frame_err`; `clk_div` is unchanged. Either way go to SYNC.
- **Abort:** `rx_ferr` in any state other than SYNC → `frame_err`, go to SYNC. `rx_ferr` in SYNC is silent.
- **Timeout:** the counter runs while the parser is not in SYNC. It clears on every `byte_valid`. When it reaches TIMEOUT_CLKS → `frame_err`, go to SYNC, partial frame dropped.
- **Simultaneous events:** `byte_valid` beats timeout in the same cycle. The byte is processed and the timer cleared.
- **Divider of zero:** always rejected, so the downstream divider never receives 0.

## Timing
- **Reset values:** `clk_div` = DIV_RESET, `cmd_ack` = 0, `frame_err` = 0. Parser in SYNC, receiver in IDLE, counters 0.
- **Reset mid-frame:** all partial state is discarded and `clk_div` returns to DIV_RESET on the next edge.
- **Input latency:** from the `uart_rx` edge to the synced bit is 2 cycles.
- **Update latency:** the stop-bit sample cycle is N. `byte_valid` is registered at N+1. `clk_div` and `cmd_ack` update together at N+2.
- **Output stability:** `clk_div` changes only in that cycle and is otherwise constant.
- **Pulses:** `cmd_ack` and `frame_err` are never high together and are exactly 1 cycle wide.
- **Byte rate:** back-to-back bytes at the full line rate are accepted with no gaps needed.

## Structure
- **Shared package `freq_cmd_pkg`:** holds `SYNC_BYTE` = 8'hA5, `CMD_SET_DIV` = 8'h01, and the parser state encodings. The host-side tools use the same constants.
- **Sub-module `uart_byte_rx`:** contains the synchroniser and the byte receiver. Outputs `byte_valid`, `byte_data[7:0]` and `rx_ferr`. The top level holds the parser, the timeout counter and the `clk_div` register.

## Test plan
Bench uses CLKS_PER_BIT = 4 and TIMEOUT_CLKS = 80.
- **Valid frame:** reset, then send `A5 01 00 01 86 A0 26` → `clk_div` = 32'd100000. One `cmd_ack` pulse 2 cycles after the last stop sample. No `frame_err`.
- **Bad checksum:** send `A5 01 00 01 86 A0 27` → one `frame_err` pulse; `clk_div` holds its prior value (1000).
- **Zero divider:** send `A5 01 00 00 00 00 01` → `frame_err`; `clk_div` unchanged.
- **Framing error mid-frame:** send `A5 01 00`, then a byte with stop = 0, then a full valid frame for 32'h3E8 (`A5 01 00 00 03 E8 EA`). Expect one `frame_err` for the broken frame, then `cmd_ack` with `clk_div` = 1000.
- **Timeout:** send `A5 01 00`, then idle 100 cycles → `frame_err` at 80 cycles after the last `byte_valid`. A following valid frame is accepted.
- **Reset mid-frame:** load 100000, start a new frame, assert `rst` for 1 cycle → `clk_div` = 1000 next cycle. Remaining bytes of that frame are ignored until the next `A5`.
